// File: rtl/wb_daq_pkg.sv
// Shared constants, FSM encoding and lane helpers for the DAQ sample packer.
package wb_daq_pkg;

    localparam int DAQ_DW      = 32;
    localparam int DAQ_ADC_DW  = 8;
    localparam int DAQ_FIFO_AW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } daq_state_e;

    // Samples per output word.
    function automatic int daq_spw(input int dw, input int adc_dw);
        return dw / adc_dw;
    endfunction

    // Width of the lane index; at least one bit so ports stay legal.
    function automatic int daq_lane_w(input int dw, input int adc_dw);
        return (dw / adc_dw > 1) ? $clog2(dw / adc_dw) : 1;
    endfunction

endpackage

// File: rtl/wb_daq_sync_fifo.sv
// Single-clock show-ahead FIFO: registered head, separate level counter,
// drop strobe when a push hits a full FIFO with no pop in the same cycle.
module wb_daq_sync_fifo #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          drop
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [AW:0]   level_q;
    logic [DW-1:0] head_q;
    logic          do_push, do_pop;

    // Empty is judged before any same-cycle push, so a pop on empty is dropped;
    // a full FIFO still accepts a push when a pop frees the slot.
    assign empty   = (level_q == '0);
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign rd_nxt  = rd_ptr_q + 1'b1;
    assign head    = head_q;
    assign level   = level_q;

    // Storage array, no reset needed: contents are qualified by level.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Pointers, level counter and the registered head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_nxt;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            // Head holds its last value once the FIFO drains.
            if (empty && do_push) begin
                head_q <= wdata;
            end else if (do_pop) begin
                if (level_q > (AW+1)'(1)) head_q <= mem_q[rd_nxt];
                else if (do_push)         head_q <= wdata;
            end
        end
    end

endmodule

// File: rtl/wb_daq_sample_packer.sv
// Packs narrow ADC samples little-endian into bus words and buffers them
// for the DAQ bus master; start_sram requests service while words are held.
module wb_daq_sample_packer
    import wb_daq_pkg::*;
#(
    parameter int dw      = DAQ_DW,
    parameter int adc_dw  = DAQ_ADC_DW,
    parameter int fifo_aw = DAQ_FIFO_AW
) (
    input  logic                                wb_clk,
    input  logic                                wb_rst,
    input  logic                                enable,
    input  logic                                sample_valid,
    input  logic [adc_dw-1:0]                   sample_data,
    input  logic                                flush,
    input  logic                                data_ack,
    input  logic                                overflow_clear,
    output logic [dw-1:0]                       data_out,
    output logic                                start_sram,
    output logic [fifo_aw:0]                    fifo_level,
    output logic [daq_lane_w(dw, adc_dw)-1:0]   lane,
    output logic                                overflow
);
    localparam int SPW = daq_spw(dw, adc_dw);
    localparam int LW  = daq_lane_w(dw, adc_dw);

    daq_state_e    state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [dw-1:0] pack_q, pack_d, word;
    logic [dw-1:0] push_word;
    logic          push;
    logic          overflow_q;
    logic          fifo_full, fifo_empty, fifo_drop;

    // Next-state, lane/pack update and push generation.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        pack_d    = pack_q;
        word      = pack_q;
        push      = 1'b0;
        push_word = pack_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = PACK;
            end
            PACK: begin
                if (!enable) begin
                    // Partial word is discarded; buffered words stay.
                    state_d = IDLE;
                    lane_d  = '0;
                    pack_d  = '0;
                end else begin
                    if (sample_valid) word[lane_q*adc_dw +: adc_dw] = sample_data;
                    if (sample_valid && lane_q == LW'(SPW-1)) begin
                        push      = 1'b1;
                        push_word = word;
                        lane_d    = '0;
                        pack_d    = '0;
                    end else if (sample_valid) begin
                        lane_d = lane_q + 1'b1;
                        pack_d = word;
                    end
                    // A flush that lands with the completing sample is already covered.
                    if (flush && lane_d != '0) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Unfilled lanes are zero because pack is cleared on every push.
                push      = 1'b1;
                push_word = pack_q;
                lane_d    = '0;
                pack_d    = '0;
                state_d   = enable ? PACK : IDLE;
                if (enable && sample_valid) begin
                    pack_d[adc_dw-1:0] = sample_data;
                    lane_d             = (SPW > 1) ? LW'(1) : '0;
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
                pack_d  = '0;
            end
        endcase
    end

    // FSM, lane and pack registers.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
        end
    end

    // Sticky overflow; a new drop wins over a same-cycle clear.
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst)                      overflow_q <= 1'b0;
        else if (fifo_drop && fifo_full)  overflow_q <= 1'b1;
        else if (overflow_clear)          overflow_q <= 1'b0;
    end

    wb_daq_sync_fifo #(.DW(dw), .AW(fifo_aw)) u_fifo (
        .clk   (wb_clk),
        .rst_n (wb_rst),
        .push  (push),
        .wdata (push_word),
        .pop   (data_ack),
        .head  (data_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .drop  (fifo_drop)
    );

    assign start_sram = ~fifo_empty;
    assign lane       = lane_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_wb_daq_sample_packer.sv
// Directed bench for the DAQ sample packer with hand-computed expectations.
module tb_wb_daq_sample_packer;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_data = '0;
    logic        flush = 1'b0;
    logic        data_ack = 1'b0;
    logic        overflow_clear = 1'b0;
    logic [31:0] data_out;
    logic        start_sram;
    logic [3:0]  fifo_level;
    logic [1:0]  lane;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    wb_daq_sample_packer dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .enable         (enable),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .flush          (flush),
        .data_ack       (data_ack),
        .overflow_clear (overflow_clear),
        .data_out       (data_out),
        .start_sram     (start_sram),
        .fifo_level     (fifo_level),
        .lane           (lane),
        .overflow       (overflow)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Word i is built from samples 4i, 4i+1, 4i+2, 4i+3 (lane 0 first).
    function automatic logic [31:0] mk(input int i);
        return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    endfunction

    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic send_word(input int i);
        for (int k = 0; k < 4; k++) send(8'(4*i+k));
    endtask

    task automatic ack();
        data_ack = 1'b1;
        step();
        data_ack = 1'b0;
    endtask

    logic [31:0] exp_q[$];

    initial begin
        // Reset state
        step(); step();
        chk("rst_data", data_out, 32'h0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_start", 32'(start_sram), 0);
        chk("rst_lane", 32'(lane), 0);
        chk("rst_ovf", 32'(overflow), 0);
        wb_rst = 1'b1;
        step();

        // Basic packing
        enable = 1'b1;
        step();
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("basic_data", data_out, 32'h44332211);
        chk("basic_level", 32'(fifo_level), 1);
        chk("basic_start", 32'(start_sram), 1);
        ack();
        chk("basic_pop_level", 32'(fifo_level), 0);
        chk("basic_pop_start", 32'(start_sram), 0);
        chk("basic_hold", data_out, 32'h44332211);
        ack();
        chk("ack_empty_level", 32'(fifo_level), 0);

        // Flush of a partial word
        send(8'hAA); send(8'hBB);
        chk("flush_lane_pre", 32'(lane), 2);
        flush = 1'b1; step(); flush = 1'b0;
        step();
        chk("flush_data", data_out, 32'h0000BBAA);
        chk("flush_level", 32'(fifo_level), 1);
        chk("flush_lane", 32'(lane), 0);
        flush = 1'b1; step(); flush = 1'b0;
        step();
        chk("flush_noop_level", 32'(fifo_level), 1);
        ack();

        // Sample arriving during FLUSH starts the next word
        send(8'hA1);
        flush = 1'b1; step(); flush = 1'b0;
        send(8'hC1);
        chk("fsmp_data", data_out, 32'h000000A1);
        chk("fsmp_lane", 32'(lane), 1);
        send(8'hC2); send(8'hC3); send(8'hC4);
        chk("fsmp_level", 32'(fifo_level), 2);
        ack();
        chk("fsmp_word", data_out, 32'hC4C3C2C1);
        ack();

        // Flush together with the completing sample: one push only
        send(8'hD1); send(8'hD2); send(8'hD3);
        flush = 1'b1; send(8'hD4); flush = 1'b0;
        step();
        chk("flush_full_level", 32'(fifo_level), 1);
        chk("flush_full_lane", 32'(lane), 0);
        chk("flush_full_data", data_out, 32'hD4D3D2D1);
        ack();

        // Overflow: 9 words into an 8-deep FIFO
        for (int i = 1; i <= 9; i++) send_word(i);
        chk("ovf_level", 32'(fifo_level), 8);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", data_out, mk(1));
        overflow_clear = 1'b1; step(); overflow_clear = 1'b0;
        chk("ovf_clear", 32'(overflow), 0);
        for (int k = 0; k < 3; k++) send(8'(40+k));
        data_ack = 1'b1; send(8'(43)); data_ack = 1'b0;
        chk("ovf_pp_level", 32'(fifo_level), 8);
        chk("ovf_pp_flag", 32'(overflow), 0);
        chk("ovf_pp_head", data_out, mk(2));
        for (int i = 2; i <= 8; i++) exp_q.push_back(mk(i));
        exp_q.push_back(mk(10));
        foreach (exp_q[i]) begin
            chk($sformatf("drain%0d", i), data_out, exp_q[i]);
            ack();
        end
        chk("drain_level", 32'(fifo_level), 0);

        // Disable mid-word discards the partial word
        send(8'h01); send(8'h02);
        enable = 1'b0; step();
        chk("dis_lane", 32'(lane), 0);
        enable = 1'b1; step();
        send(8'h05); send(8'h06); send(8'h07); send(8'h08);
        chk("dis_data", data_out, 32'h08070605);
        chk("dis_level", 32'(fifo_level), 1);
        ack();

        // Pointer wrap: push and pop one word at a time
        for (int i = 20; i < 40; i++) begin
            send_word(i);
            chk($sformatf("wrap%0d_data", i), data_out, mk(i));
            chk($sformatf("wrap%0d_level", i), 32'(fifo_level), 1);
            ack();
        end
        chk("wrap_empty", 32'(fifo_level), 0);

        // Asynchronous reset mid-word with three words buffered
        send_word(50); send_word(51); send_word(52);
        chk("ar_level_pre", 32'(fifo_level), 3);
        send(8'hE1); send(8'hE2);
        #2 wb_rst = 1'b0;
        #1;
        chk("ar_data", data_out, 32'h0);
        chk("ar_level", 32'(fifo_level), 0);
        chk("ar_start", 32'(start_sram), 0);
        chk("ar_lane", 32'(lane), 0);
        chk("ar_ovf", 32'(overflow), 0);
        step();
        wb_rst = 1'b1;
        step();
        send_word(53);
        chk("ar_first_word", data_out, mk(53));
        chk("ar_first_level", 32'(fifo_level), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_daq_sample_packer.md
Name: wb_daq_sample_packer

Overview:
Per-channel stage directly upstream of the DAQ bus master and channel arbiter. It packs narrow ADC samples into bus-width words, little-endian, and buffers them in a small show-ahead FIFO. It raises start_sram while the FIFO holds words, and pops one word on each completed bus-master write acknowledge. Everything runs in the wb_clk domain; ADC samples arrive already synchronised.

Parameters:
dw, 32, output word width
adc_dw, 8, sample width; dw must be an integer multiple of adc_dw
fifo_aw, 3, FIFO address width; depth = 2**fifo_aw words (8)

Ports:
wb_clk  input  1  system clock, rising edge
wb_rst  input  1  asynchronous, active-low reset
enable  input  1  channel enable (master_enable AND channel control enable)
sample_valid  input  1  one-cycle strobe, sample_data valid
sample_data  input  adc_dw  ADC sample
flush  input  1  pulse: commit partial word
data_ack  input  1  pulse: head word written by bus master, pop
overflow_clear  input  1  pulse: clear sticky overflow
data_out  output  dw  FIFO head word (show-ahead)
start_sram  output  1  request to arbiter, high while FIFO not empty
fifo_level  output  fifo_aw+1  words stored, 0..depth
lane  output  log2(dw/adc_dw)  next lane to fill
overflow  output  1  sticky: a word was dropped

Behaviour:
- Reset (wb_rst low, async): FSM=IDLE, lane=0, pack register=0, FIFO empty, fifo_level=0, start_sram=0, data_out=0, overflow=0.
- Constants: SPW = dw/adc_dw (4). Lane k occupies bits [k*adc_dw +: adc_dw]. The first sample goes to lane 0.
- FSM states are IDLE, PACK and FLUSH.
  - IDLE: enable=1 moves to PACK. Samples are ignored.
  - PACK, enable=0: go to IDLE; lane=0; pack register cleared; partial word discarded; FIFO contents kept.
  - PACK, flush=1 with lane>0 after the current sample is applied: go to FLUSH.
  - FLUSH: push the partial word with unfilled lanes zero, lane=0, return to PACK next cycle. A sample arriving during FLUSH goes to lane 0 of the new word.
- Packing: sample_valid in PACK writes the lane and increments lane.
  - When lane=SPW-1, the completed word (including this sample) is pushed the same cycle and lane wraps to 0.
  - The pushed word appears on data_out and fifo_level one cycle later, or stays behind the existing head.
- Flush arriving with the word-completing sample: normal push only, no FLUSH state.
- Flush with lane=0 and no sample: no-op.
- FIFO:
  - Head is registered. data_out shows the head whenever non-empty and holds its last value when empty.
  - data_ack pops. data_ack while empty is ignored.
  - start_sram = (fifo_level != 0), registered.
  - Push into a full FIFO with no pop in the same cycle: word dropped, overflow=1 next cycle, FIFO unchanged.
  - Push and pop in the same cycle when full: both occur, level stays at depth, no overflow.
  - Push and pop in the same cycle when empty: the word is stored and level goes to 1. The pop is ignored because empty is evaluated before the push.
  - Pointers wrap modulo depth. fifo_level is a separate counter, not pointer difference.
- overflow_clear clears overflow. If an overflow event happens in the same cycle, set wins.
- Asynchronous reset mid-word or mid-FLUSH returns to the reset state immediately. No partial word is pushed.

Decomposition:
- Package wb_daq_pkg holds: the state encoding (IDLE=2'd0, PACK=2'd1, FLUSH=2'd2), a SPW/lane-width helper function, and the default dw/adc_dw/fifo_aw constants shared with the channel and top.
- Sub-module wb_daq_sync_fifo, a generic single-clock show-ahead FIFO with push, pop, full, empty, level and a drop indication. The packer instantiates it once.

Test Plan:
- Basic packing: enable=1, samples 0x11,0x22,0x33,0x44 -> one cycle after the 4th sample, data_out=0x44332211, fifo_level=1, start_sram=1. Then data_ack -> level 0, start_sram=0.
- Flush: samples 0xAA,0xBB, then flush -> data_out=0x0000BBAA, lane=0. Flush with lane=0 -> no push.
- Overflow: 9 full words with no data_ack -> level=8 and overflow=1 after the 9th. The head is still word 1. Word 10 pushed together with a data_ack -> level stays 8, no new drop. overflow_clear -> overflow=0.
- Disable mid-word: samples 0x01,0x02, then enable=0 for one cycle, re-enable, then 0x05,0x06,0x07,0x08 -> data_out=0x08070605 (partial word discarded).
- Wrap: 20 words pushed and popped one at a time -> data_out order matches push order across pointer wrap, level never exceeds 1.
- Async reset: assert wb_rst low mid-word with level=3 -> all outputs 0 immediately. After release, the first 4 samples form the first word.
